// File: rtl/bubbledrive8_flash_arbiter_if.sv
// Bus bundle between the two SPI requesters, the flash arbiter and the W25Q32 pads.
// The arbiter connects through the slave modport; the requester/pad side uses master.
interface bubbledrive8_flash_arbiter_if;
    logic       REQ0;
    logic       REQ1;
    logic       GNT0;
    logic       GNT1;
    logic       nCS0;
    logic       MOSI0;
    logic       SCLK0;
    logic       nCS1;
    logic       MOSI1;
    logic       SCLK1;
    logic       MISO;
    logic       nROMCS;
    logic       ROMMOSI;
    logic       ROMCLK;
    logic       ROMMISO;
    logic       BUSY;
    logic [1:0] TOERR;

    modport master (
        output REQ0, REQ1, nCS0, MOSI0, SCLK0, nCS1, MOSI1, SCLK1, ROMMISO,
        input  GNT0, GNT1, MISO, nROMCS, ROMMOSI, ROMCLK, BUSY, TOERR
    );

    modport slave (
        input  REQ0, REQ1, nCS0, MOSI0, SCLK0, nCS1, MOSI1, SCLK1, ROMMISO,
        output GNT0, GNT1, MISO, nROMCS, ROMMOSI, ROMCLK, BUSY, TOERR
    );
endinterface

// File: rtl/bubbledrive8_flash_arbiter.sv
// Two-master arbiter for the shared SPI image flash, with nROMCS guard gap and grant timeout.
// Define FLASH_ARB_ROUNDROBIN_EN for round-robin tie breaking; default is fixed priority to port 0.
module bubbledrive8_flash_arbiter #(
    parameter int GUARD_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 4800000
) (
    input logic                      MCLK,
    input logic                      nRESET,
    bubbledrive8_flash_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GUARD} state_t;

    localparam logic [23:0] HOLD_LAST  = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0] GUARD_LOAD = 24'(GUARD_CYCLES - 1);

    state_t      state, state_next;
    logic [23:0] hold_cnt, hold_cnt_next;
    logic [23:0] guard_cnt, guard_cnt_next;
    logic [1:0]  lockout, lockout_next;
    logic [1:0]  toerr, toerr_next;
    logic        cs_next, clk_next, mosi_next;
    logic        elig0, elig1, pick1;

    assign elig0 = bus.REQ0 && !lockout[0];
    assign elig1 = bus.REQ1 && !lockout[1];

`ifdef FLASH_ARB_ROUNDROBIN_EN
    logic last_owner;

    // On a tie the port that did not own the flash last time wins.
    assign pick1 = elig1 && (!elig0 || !last_owner);

    always_ff @(posedge MCLK) begin
        if (!nRESET)
            last_owner <= 1'b1;
        else if (state == IDLE && (elig0 || elig1))
            last_owner <= pick1;
    end
`else
    assign pick1 = elig1 && !elig0;
`endif

    always_ff @(posedge MCLK) begin
        if (!nRESET) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            guard_cnt   <= '0;
            lockout     <= '0;
            toerr       <= '0;
            bus.GNT0    <= 1'b0;
            bus.GNT1    <= 1'b0;
            bus.nROMCS  <= 1'b1;
            bus.ROMCLK  <= 1'b0;
            bus.ROMMOSI <= 1'b0;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_cnt_next;
            guard_cnt   <= guard_cnt_next;
            lockout     <= lockout_next;
            toerr       <= toerr_next;
            bus.GNT0    <= (state_next == GRANT0);
            bus.GNT1    <= (state_next == GRANT1);
            bus.nROMCS  <= cs_next;
            bus.ROMCLK  <= clk_next;
            bus.ROMMOSI <= mosi_next;
        end
    end

    always_comb begin
        state_next     = state;
        hold_cnt_next  = hold_cnt;
        guard_cnt_next = guard_cnt;
        lockout_next   = lockout;
        toerr_next     = toerr;
        unique case (state)
            IDLE: begin
                if (elig0 || elig1) begin
                    state_next    = pick1 ? GRANT1 : GRANT0;
                    hold_cnt_next = '0;
                end
            end
            GRANT0: begin
                if (!bus.REQ0) begin
                    state_next     = GUARD;
                    guard_cnt_next = GUARD_LOAD;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next      = GUARD;
                    guard_cnt_next  = GUARD_LOAD;
                    toerr_next[0]   = 1'b1;
                    lockout_next[0] = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt + 24'd1;
                end
            end
            GRANT1: begin
                if (!bus.REQ1) begin
                    state_next     = GUARD;
                    guard_cnt_next = GUARD_LOAD;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next      = GUARD;
                    guard_cnt_next  = GUARD_LOAD;
                    toerr_next[1]   = 1'b1;
                    lockout_next[1] = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt + 24'd1;
                end
            end
            GUARD: begin
                if (guard_cnt == '0)
                    state_next = IDLE;
                else
                    guard_cnt_next = guard_cnt - 24'd1;
            end
            default: state_next = IDLE;
        endcase
        // A lockout lasts only until the locked-out requester lets go once.
        if (!bus.REQ0)
            lockout_next[0] = 1'b0;
        if (!bus.REQ1)
            lockout_next[1] = 1'b0;
    end

    // Pins follow the owner only while it keeps the grant; otherwise they are parked idle.
    always_comb begin
        cs_next   = 1'b1;
        clk_next  = 1'b0;
        mosi_next = 1'b0;
        if (state == GRANT0 && state_next == GRANT0) begin
            cs_next   = bus.nCS0;
            clk_next  = bus.SCLK0;
            mosi_next = bus.MOSI0;
        end else if (state == GRANT1 && state_next == GRANT1) begin
            cs_next   = bus.nCS1;
            clk_next  = bus.SCLK1;
            mosi_next = bus.MOSI1;
        end
    end

    assign bus.MISO  = bus.ROMMISO;
    assign bus.BUSY  = (state != IDLE);
    assign bus.TOERR = toerr;

endmodule
